// File: rtl/rr_arbiter4.sv
// Four-master round-robin arbiter with registered one-hot grant, hold limit with
// forced release, global inhibit, and a one-cycle dead gap on every handover.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       C,
    input  logic       CLRB,
    input  logic [3:0] REQ,
    input  logic       INH,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       GNT_VLD,
    output logic       PREEMPT
);

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    last;
    logic [CW-1:0] cnt;

    logic [3:0]    eligible;
    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    scan_idx;
    logic          owner_req;
    logic          others_waiting;
    logic          hold_expired;
    logic          vol_release;
    logic          forced_release;

    assign eligible = REQ & ~{4{INH}};

    // Scan starts just after the last owner, so the previous owner ends up last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last + k[1:0];
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign owner_req      = REQ[GNT_ID];
    assign others_waiting = |(eligible & ~GNT);
    assign hold_expired   = (MAX_HOLD != 0) && (cnt == HOLD_MAX);
    assign vol_release    = (state == GRANT) && !owner_req;
    assign forced_release = (state == GRANT) && owner_req && hold_expired && others_waiting;

    always_ff @(posedge C or negedge CLRB) begin
        if (!CLRB) begin
            state   <= IDLE;
            last    <= 2'd3;
            cnt     <= '0;
            GNT     <= 4'b0000;
            GNT_ID  <= 2'd0;
            GNT_VLD <= 1'b0;
            PREEMPT <= 1'b0;
        end else begin
            PREEMPT <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (win_found) begin
                        state   <= GRANT;
                        GNT     <= 4'b0001 << win_idx;
                        GNT_ID  <= win_idx;
                        GNT_VLD <= 1'b1;
                        cnt     <= CNT_ONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (vol_release || forced_release) begin
                        state   <= GAP;
                        last    <= GNT_ID;
                        GNT     <= 4'b0000;
                        GNT_ID  <= 2'd0;
                        GNT_VLD <= 1'b0;
                        cnt     <= '0;
                        PREEMPT <= forced_release;
                    end else if ((MAX_HOLD != 0) && (cnt < HOLD_MAX)) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    GNT     <= 4'b0000;
                    GNT_ID  <= 2'd0;
                    GNT_VLD <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 with MAX_HOLD=4: a vector table plus hand-written
// sequences for lone-owner saturation and asynchronous clear during a grant.
module tb_rr_arbiter4;

    logic       C;
    logic       CLRB;
    logic [3:0] REQ;
    logic       INH;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       GNT_VLD;
    logic       PREEMPT;

    int errors;
    int checks;

    typedef struct {
        logic [3:0] req;
        logic       inh;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter4 #(.MAX_HOLD(4)) dut (
        .C       (C),
        .CLRB    (CLRB),
        .REQ     (REQ),
        .INH     (INH),
        .GNT     (GNT),
        .GNT_ID  (GNT_ID),
        .GNT_VLD (GNT_VLD),
        .PREEMPT (PREEMPT)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic applyStimulus(input logic [3:0] req, input logic inh);
        REQ = req;
        INH = inh;
        @(posedge C);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] gnt, input logic [1:0] id,
                               input logic vld, input logic pre);
        checks++;
        if ({GNT, GNT_ID, GNT_VLD, PREEMPT} !== {gnt, id, vld, pre}) begin
            errors++;
            $display("[TB] FAIL %s: got GNT=%b ID=%0d VLD=%b PRE=%b, expected GNT=%b ID=%0d VLD=%b PRE=%b",
                     name, GNT, GNT_ID, GNT_VLD, PREEMPT, gnt, id, vld, pre);
        end
    endtask

    task automatic addVec(input logic [3:0] req, input logic inh, input logic [3:0] gnt,
                          input logic [1:0] id, input logic vld, input logic pre);
        vec_t v;
        v.req = req; v.inh = inh; v.gnt = gnt; v.id = id; v.vld = vld; v.pre = pre;
        vecs.push_back(v);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        CLRB   = 1'b0;
        REQ    = 4'b1111;
        INH    = 1'b0;

        // First grant and round-robin rotation with one dead cycle per handover
        addVec(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        addVec(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        addVec(4'b1110, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        addVec(4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        addVec(4'b1101, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b1011, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        addVec(4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        addVec(4'b0111, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        addVec(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        // Forced release after exactly four granted cycles
        addVec(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b1100, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b1100, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b1100, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b1100, 0, 4'b0000, 2'd0, 0, 1);
        addVec(4'b1100, 0, 4'b1000, 2'd3, 1, 0);
        addVec(4'b0100, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        // Voluntary release at the hold limit wins over the forced one: no pulse
        addVec(4'b0110, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0110, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0110, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0010, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        addVec(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        // Inhibit blocks new grants, keeps an existing one, and suppresses preemption
        addVec(4'b0100, 1, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0100, 1, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0101, 1, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0101, 1, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0101, 1, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0101, 1, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0101, 1, 4'b0100, 2'd2, 1, 0);
        addVec(4'b0101, 0, 4'b0000, 2'd0, 0, 1);
        addVec(4'b0101, 0, 4'b0001, 2'd0, 1, 0);
        addVec(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        addVec(4'b0000, 0, 4'b0000, 2'd0, 0, 0);

        #2;
        checkOutput("reset_state", 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b1111, 0);
            checkOutput("held_in_reset", 4'b0000, 2'd0, 0, 0);
        end
        CLRB = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].inh);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].vld, vecs[i].pre);
        end

        // Lone owner keeps the grant past the hold limit with no preemption
        for (int i = 0; i < 21; i++) begin
            applyStimulus(4'b0010, 0);
            checkOutput($sformatf("lone_%0d", i), 4'b0010, 2'd1, 1, 0);
        end
        applyStimulus(4'b0000, 0);
        checkOutput("lone_release", 4'b0000, 2'd0, 0, 0);
        applyStimulus(4'b0000, 0);

        // Asynchronous clear between edges while master 3 owns the resource
        applyStimulus(4'b1000, 0);
        checkOutput("pre_clear_grant", 4'b1000, 2'd3, 1, 0);
        #2;
        CLRB = 1'b0;
        #1;
        checkOutput("async_clear", 4'b0000, 2'd0, 0, 0);
        REQ = 4'b1001;
        #1;
        CLRB = 1'b1;
        applyStimulus(4'b1001, 0);
        checkOutput("grant_after_clear", 4'b0001, 2'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as a gated AND-type datapath or a shared primitive slice, among up to four masters. It issues a registered one-hot grant and holds it while the owner keeps requesting. It forces release after a programmable hold limit when another master is waiting, and a global inhibit input blocks new grants. Each handover inserts one dead cycle so the shared resource never sees overlapping owners.

## Interface

Parameters:
- MAX_HOLD, 16: maximum consecutive granted cycles before a forced release when others are waiting; 0 disables the limit.

Ports:
- C, input, 1: clock; all state updates on the rising edge.
- CLRB, input, 1: clear; asynchronous, active-low.
- REQ, input, 4: request per master; level-sensitive, bit i belongs to master i.
- INH, input, 1: inhibit, active-high; blocks new grants and never revokes an existing grant.
- GNT, output, 4: one-hot grant; all zero when no owner.
- GNT_ID, output, 2: index of the current owner; 0 when GNT_VLD is 0.
- GNT_VLD, output, 1: high whenever any GNT bit is high.
- PREEMPT, output, 1: one-cycle pulse in the first cycle after a forced release.

## Operation

- State: FSM {IDLE, GRANT, GAP}; LAST[1:0] holds the last owner; hold counter CNT is clog2(MAX_HOLD+1) bits wide, minimum 1.
- Eligible set: REQ & ~{4{INH}}.
- Arbitration runs in IDLE and GAP. The winner is the first eligible index scanning LAST+1, LAST+2, LAST+3, LAST+4, all mod 4.
- A winning edge loads GNT with the one-hot winner, GNT_ID with the winner index, CNT with 1, and moves state to GRANT.
- GAP lasts exactly one cycle. It still arbitrates, so a handover costs exactly one dead cycle. With no eligible request, GAP goes to IDLE.
- GRANT, voluntary release: REQ[GNT_ID]==0 at an edge clears GNT, sets LAST to GNT_ID, and moves state to GAP.
- GRANT, forced release: MAX_HOLD!=0, CNT==MAX_HOLD, and some eligible request other than the owner at an edge. This clears GNT, sets LAST to the owner, moves state to GAP, and asserts PREEMPT for one cycle.
- GRANT otherwise: the grant holds and CNT increments, saturating at MAX_HOLD.
- Voluntary release takes precedence over forced release at the same edge. PREEMPT stays 0 in that case.
- A pre-empted owner keeping REQ high takes the lowest round-robin priority on the next arbitration.
- INH asserted during GRANT has no effect on the current grant. INH suppresses the forced release, because no eligible competitor exists.
- Requests from non-owners during GRANT are ignored until release.

## Timing

- Reset (CLRB low) takes effect immediately and asynchronously:
  - GNT=0, GNT_ID=0, GNT_VLD=0, PREEMPT=0.
  - State IDLE, LAST=3, CNT=0.
  - Because LAST resets to 3, master 0 has top priority after reset.
- Reset deassertion mid-operation: the first edge with CLRB high arbitrates from IDLE.
- Grant latency: REQ and INH are sampled at edge k. GNT is visible after edge k, one clock from request to grant.
- Release latency: REQ[owner] dropping is sampled at edge k, and GNT drops after edge k. The next owner's GNT appears after edge k+1.
- Maximum continuous grant with competitors present is exactly MAX_HOLD cycles.
- Worst-case wait for a continuously requesting master with INH low is 3·(MAX_HOLD+1) cycles.
- All outputs are registered. There are no combinational paths from REQ or INH to any output.

## Test plan

- Reset and first grant:
  - Stimulus: CLRB low, then high; REQ=4'b1111 at edge 1.
  - Response: GNT=4'b0001 and GNT_ID=0 after edge 1; GNT=0 while CLRB low.
- Round-robin rotation:
  - Stimulus: REQ=4'b1111; each owner drops its REQ bit for one cycle after 2 granted cycles, then raises it again.
  - Response: grant order 0,1,2,3,0; exactly one GNT=0 cycle between owners.
- Forced release:
  - Stimulus: MAX_HOLD=4; master 2 holds REQ; master 3 requests from cycle 1.
  - Response: GNT[2] high for exactly 4 cycles, then one cycle with GNT=0 and PREEMPT=1, then GNT=4'b1000.
- Lone owner saturation:
  - Stimulus: MAX_HOLD=4; only master 1 requests, for 20 cycles.
  - Response: GNT=4'b0010 continuously for 20 cycles, PREEMPT never asserts.
- Inhibit:
  - Stimulus: INH=1 with REQ=4'b0100.
  - Response: GNT stays 0. With INH raised during an active grant and another master waiting past MAX_HOLD, the grant holds with no PREEMPT.
- Async reset mid-grant:
  - Stimulus: CLRB pulsed low between edges while GNT=4'b1000.
  - Response: GNT=0 immediately, without waiting for an edge; with REQ=4'b1001, the next grant goes to master 0.
